// File: rtl/fft_pkg.sv
// Shared FFT definitions: data/twiddle widths, control-state encoding and
// the saturate-to-data-width helper used by every butterfly stage.
package fft_pkg;

  localparam int DATA_W  = 19;
  localparam int TW_W    = 9;
  localparam int TW_FRAC = 7;
  localparam int DEPTH   = 16;
  localparam int PTR_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FIRST   = 2'b01,
    SECOND  = 2'b10,
    WAITING = 2'b11
  } bf_state_e;

  localparam logic signed [31:0] SAT_HI = (32'sd1 <<< (DATA_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_LO = -(32'sd1 <<< (DATA_W - 1));

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [31:0] v);
    if (v > SAT_HI)
      return SAT_HI[DATA_W-1:0];
    else if (v < SAT_LO)
      return SAT_LO[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/bf_stage16_if.sv
// Sample/twiddle/control bundle between the stage-1 control unit (master)
// and the 16-deep butterfly stage (slave), plus the stage result stream.
interface bf_stage16_if;
  import fft_pkg::*;

  bf_state_e                state;
  logic signed [DATA_W-1:0] data_in_r;
  logic signed [DATA_W-1:0] data_in_i;
  logic signed [TW_W-1:0]   WN_r;
  logic signed [TW_W-1:0]   WN_i;
  logic signed [DATA_W-1:0] data_out_r;
  logic signed [DATA_W-1:0] data_out_i;
  logic                     valid_o;
  logic                     last_o;

  modport master (
    output state, data_in_r, data_in_i, WN_r, WN_i,
    input  data_out_r, data_out_i, valid_o, last_o
  );

  modport slave (
    input  state, data_in_r, data_in_i, WN_r, WN_i,
    output data_out_r, data_out_i, valid_o, last_o
  );

endinterface

// File: rtl/cmul_q7.sv
// Combinational complex multiply by a Q2.7 twiddle, round-half-up on the
// dropped fraction, saturated back to the data width.
module cmul_q7
  import fft_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [TW_W-1:0]   w_r,
  input  logic signed [TW_W-1:0]   w_i,
  output logic signed [DATA_W-1:0] p_r,
  output logic signed [DATA_W-1:0] p_i
);

  localparam int PW = DATA_W + TW_W + 1;
  localparam logic signed [PW-1:0] RND =
    {{(PW - TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC - 1){1'b0}}};

  logic signed [PW-1:0] ar, ai, wr, wi;
  logic signed [PW-1:0] re, im, re_s, im_s;

  assign ar = {{(PW - DATA_W){a_r[DATA_W-1]}}, a_r};
  assign ai = {{(PW - DATA_W){a_i[DATA_W-1]}}, a_i};
  assign wr = {{(PW - TW_W){w_r[TW_W-1]}}, w_r};
  assign wi = {{(PW - TW_W){w_i[TW_W-1]}}, w_i};

  // Products fit in PW bits, so truncating to PW keeps exact values.
  assign re   = ar * wr - ai * wi + RND;
  assign im   = ar * wi + ai * wr + RND;
  assign re_s = re >>> TW_FRAC;
  assign im_s = im >>> TW_FRAC;

  assign p_r = sat_data({{(32 - PW){re_s[PW-1]}}, re_s});
  assign p_i = sat_data({{(32 - PW){im_s[PW-1]}}, im_s});

endmodule

// File: rtl/bf_stage16.sv
// First radix-2 SDF butterfly (16-deep feedback) of the 32-point FFT.
// Build option BF16_SCALE_EN: halve the butterfly sum/difference instead of saturating.
module bf_stage16
  import fft_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  bf_stage16_if.slave bus
);

  logic signed [DATA_W-1:0] dl_r [DEPTH];
  logic signed [DATA_W-1:0] dl_i [DEPTH];
  logic [PTR_W-1:0]         ptr;
  logic [CNT_W-1:0]         cnt;

  logic signed [DATA_W-1:0] d_r, d_i;
  logic signed [DATA_W-1:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [DATA_W-1:0] mul_r, mul_i;

  function automatic logic signed [DATA_W-1:0] bf_res(input logic signed [DATA_W:0] v);
`ifdef BF16_SCALE_EN
    logic signed [DATA_W+1:0] t;
    t = {v[DATA_W], v} + {{(DATA_W + 1){1'b0}}, 1'b1};
    return t[DATA_W:1];
`else
    return sat_data({{(31 - DATA_W){v[DATA_W]}}, v});
`endif
  endfunction

  // Combinational read returns the pre-write value of the entry at ptr.
  assign d_r = dl_r[ptr];
  assign d_i = dl_i[ptr];

  assign sum_r = bf_res({d_r[DATA_W-1], d_r} + {bus.data_in_r[DATA_W-1], bus.data_in_r});
  assign sum_i = bf_res({d_i[DATA_W-1], d_i} + {bus.data_in_i[DATA_W-1], bus.data_in_i});
  assign dif_r = bf_res({d_r[DATA_W-1], d_r} - {bus.data_in_r[DATA_W-1], bus.data_in_r});
  assign dif_i = bf_res({d_i[DATA_W-1], d_i} - {bus.data_in_i[DATA_W-1], bus.data_in_i});

  cmul_q7 u_cmul (
    .a_r (d_r),
    .a_i (d_i),
    .w_r (bus.WN_r),
    .w_i (bus.WN_i),
    .p_r (mul_r),
    .p_i (mul_i)
  );

  always_ff @(posedge clk) begin
    case (bus.state)
      WAITING: begin
        dl_r[ptr] <= bus.data_in_r;
        dl_i[ptr] <= bus.data_in_i;
      end
      FIRST: begin
        dl_r[ptr] <= dif_r;
        dl_i[ptr] <= dif_i;
      end
      SECOND: begin
        dl_r[ptr] <= '0;
        dl_i[ptr] <= '0;
      end
      IDLE: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr            <= '0;
      cnt            <= '0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
      bus.valid_o    <= 1'b0;
      bus.last_o     <= 1'b0;
    end else begin
      case (bus.state)
        IDLE: begin
          ptr         <= '0;
          cnt         <= '0;
          bus.valid_o <= 1'b0;
          bus.last_o  <= 1'b0;
        end
        WAITING: begin
          ptr         <= ptr + PTR_W'(1);
          bus.valid_o <= 1'b0;
          bus.last_o  <= 1'b0;
        end
        FIRST: begin
          ptr            <= ptr + PTR_W'(1);
          cnt            <= cnt + CNT_W'(1);
          bus.data_out_r <= sum_r;
          bus.data_out_i <= sum_i;
          bus.valid_o    <= 1'b1;
          bus.last_o     <= &cnt;
        end
        SECOND: begin
          ptr            <= ptr + PTR_W'(1);
          cnt            <= cnt + CNT_W'(1);
          bus.data_out_r <= mul_r;
          bus.data_out_i <= mul_i;
          bus.valid_o    <= 1'b1;
          bus.last_o     <= &cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_stage16.sv
// Directed-vector bench for bf_stage16 with an expected-output queue and an
// independent monitor; expectations follow the BF16_SCALE_EN build option.
module tb_bf_stage16;
  import fft_pkg::*;

`ifdef BF16_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bf_stage16_if bus ();

  bf_stage16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int r;
    int i;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   xr[32], xi[32], er[32], ei[32];
  int   wr[16], wi[16];

  always @(negedge clk) begin
    if (rst && bus.valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got=(%0d,%0d,last=%0b) expected=no output",
                 bus.data_out_r, bus.data_out_i, bus.last_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(bus.data_out_r) != mon_e.r || int'(bus.data_out_i) != mon_e.i ||
            bus.last_o != mon_e.last) begin
          errors++;
          $display("FAIL out_value got=(%0d,%0d,last=%0b) expected=(%0d,%0d,last=%0b)",
                   bus.data_out_r, bus.data_out_i, bus.last_o, mon_e.r, mon_e.i, mon_e.last);
        end
      end
    end
  end

  task automatic drive(input bf_state_e s, input int a_r, input int a_i,
                       input int w_r, input int w_i);
    @(posedge clk);
    #1;
    bus.state     = s;
    bus.data_in_r = DATA_W'(a_r);
    bus.data_in_i = DATA_W'(a_i);
    bus.WN_r      = TW_W'(w_r);
    bus.WN_i      = TW_W'(w_i);
  endtask

  // First-half samples a, second-half samples b, twiddle w, sums s, rotated differences d.
  task automatic fill(input int a_r, input int a_i, input int b_r, input int b_i,
                      input int w_r, input int w_i, input int s_r, input int s_i,
                      input int d_r, input int d_i);
    for (int k = 0; k < 16; k++) begin
      xr[k] = a_r;       xi[k] = a_i;
      xr[16+k] = b_r;    xi[16+k] = b_i;
      wr[k] = w_r;       wi[k] = w_i;
      er[k] = s_r;       ei[k] = s_i;
      er[16+k] = d_r;    ei[16+k] = d_i;
    end
  endtask

  task automatic run_head(input int n_first);
    for (int k = 0; k < 16; k++) drive(WAITING, xr[k], xi[k], 0, 0);
    for (int k = 0; k < n_first; k++) begin
      exp_q.push_back('{er[k], ei[k], 1'b0});
      drive(FIRST, xr[16+k], xi[16+k], 0, 0);
    end
  endtask

  task automatic run_frame();
    run_head(16);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back('{er[16+k], ei[16+k], (k == 15)});
      drive(SECOND, 777, -555, wr[k], wi[k]);
    end
    drive(IDLE, 0, 0, 0, 0);
  endtask

  task automatic expect_drained(input string name);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s outputs_missing=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus.state     = IDLE;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    bus.WN_r      = '0;
    bus.WN_i      = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.last_o !== 1'b0 ||
        bus.data_out_r !== '0 || bus.data_out_i !== '0) begin
      errors++;
      $display("FAIL reset_state got=(%0d,%0d,valid=%0b,last=%0b) expected=(0,0,0,0)",
               bus.data_out_r, bus.data_out_i, bus.valid_o, bus.last_o);
    end
    @(posedge clk);
    #1 rst = 1'b1;

    fill(1000, 0, 1000, 0, 128, 0, SCALE ? 1000 : 2000, 0, 0, 0);
    run_frame();
    expect_drained("dc_frame");

    fill(1000, 0, -1000, 0, 0, -128, 0, 0, 0, SCALE ? -1000 : -2000);
    run_frame();
    expect_drained("sign_flip");

    fill(0, 1000, 0, 0, 0, -128, 0, SCALE ? 500 : 1000, SCALE ? 500 : 1000, 0);
    run_frame();
    expect_drained("rotate_imag");

    fill(200000, -200000, 200000, -200000, 128, 0,
         SCALE ? 200000 : 262143, SCALE ? -200000 : -262144, 0, 0);
    for (int k = 8; k < 16; k++) begin
      xr[16+k] = -200000;  xi[16+k] = 200000;
      er[k] = 0;           ei[k] = 0;
      er[16+k] = SCALE ? 200000 : 262143;
      ei[16+k] = SCALE ? -200000 : -262144;
    end
    run_frame();
    expect_drained("saturation");

    fill(3, 0, 0, 0, 64, 0, SCALE ? 2 : 3, 0, SCALE ? 1 : 2, 0);
    for (int k = 8; k < 16; k++) begin
      xr[k] = 1;  wr[k] = 63;
      er[k] = 1;  er[16+k] = 0;
    end
    run_frame();
    expect_drained("rounding");

    // Reset pulled low while FIRST is being presented for the sixth time.
    fill(1000, 0, 1000, 0, 128, 0, SCALE ? 1000 : 2000, 0, 0, 0);
    run_head(5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.last_o !== 1'b0 ||
        bus.data_out_r !== '0 || bus.data_out_i !== '0) begin
      errors++;
      $display("FAIL reset_midframe got=(%0d,%0d,valid=%0b,last=%0b) expected=(0,0,0,0)",
               bus.data_out_r, bus.data_out_i, bus.valid_o, bus.last_o);
    end
    drive(IDLE, 0, 0, 0, 0);
    drive(IDLE, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) drive(IDLE, 0, 0, 0, 0);
    run_frame();
    expect_drained("dc_after_reset");

    fill(5000, -300, 100, 200, 128, 0, SCALE ? 2550 : 5100, SCALE ? -50 : -100, 0, 0);
    run_head(8);
    drive(IDLE, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_valid_drop got=%0b expected=0", bus.valid_o);
    end
    expect_drained("abort_partial");
    fill(1000, 0, 1000, 0, 128, 0, SCALE ? 1000 : 2000, 0, 0, 0);
    run_frame();
    expect_drained("dc_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bf_stage16.md
# bf_stage16

First radix-2 single-path delay-feedback (SDF) butterfly stage of the 32-point FFT. It sits directly downstream of the stage-1 control unit and consumes that unit's `state`, `data_out_r/i` and `WN_r/i`. It holds the first 16 samples of a frame in a 16-deep feedback delay line and forms the sum and difference with the second 16 samples. It then emits the 16 sums, followed by the 16 differences rotated by the twiddle factor, to the stage-2 (8-deep) control unit.

## Interface
- `DEPTH`, 16: delay-line length (half the FFT size at this stage).
- `DATA_W`, 19: signed data width, real and imaginary.
- `TW_W`, 9: signed twiddle width, Q2.7 (1.0 = 128).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `state`  in  2: control state. IDLE=00, FIRST=01, SECOND=10, WAITING=11.
- `data_in_r`, `data_in_i`  in  19 each: sample, aligned with `state` in the same cycle.
- `WN_r`, `WN_i`  in  9 each: twiddle, valid during SECOND.
- `data_out_r`, `data_out_i`  out  19 each: stage result.
- `valid_o`  out  1: `data_out` holds a result this cycle.
- `last_o`  out  1: high with the 32nd result of the frame.

## Operation
- Delay line: 16-entry circular buffer with a 4-bit pointer `ptr`. Each cycle: read entry `ptr`, write entry `ptr`, then `ptr` increments (wraps 15→0).
- Per-cycle behaviour by state:
  - IDLE: `ptr` cleared to 0, no write. `valid_o` and `last_o` are 0 next cycle.
  - WAITING: writes `x = data_in`; no output.
  - FIRST: `d` = delay-line read. Writes `d - x`. Registers `d + x` to the output with `valid_o = 1`.
  - SECOND: writes 0. Registers `d * WN` to the output with `valid_o = 1`. `data_in` is ignored.
- Sum/difference: computed at 20 bits.
  - Without scaling, saturate to the 19-bit range [-262144, 262143].
- Complex multiply:
  - `re = d_r*WN_r - d_i*WN_i` and `im = d_r*WN_i + d_i*WN_r`, each at 29 bits.
  - Add 64, arithmetic shift right by 7, saturate to 19 bits.
- Output counter: 5 bits, counts valid outputs. `last_o` is asserted when the count is 31. The counter clears in IDLE.
- A state sequence that skips phases (e.g. FIRST→IDLE) aborts the frame. `ptr` and the counter clear, and stale delay-line contents are never emitted, because the next frame's WAITING overwrites all 16 entries before the first read.
- The encoding `state` = 11 is always treated as WAITING.

## Timing
- Reset values: `data_out_r/i` = 0, `valid_o` = 0, `last_o` = 0, `ptr` = 0, counter = 0. Delay-line contents are don't-care.
- Reset deassertion takes effect on the next rising edge. Asserting reset mid-frame clears everything immediately; that frame's outputs are lost.
- Latency is 1 cycle from input to output in both FIRST and SECOND.
  - The first FIRST-phase input appears on the output the next cycle.
  - The output stream is 32 contiguous valid cycles.
- Delay-line read-to-write: the same entry is read and written in the same cycle. The read must return the old value (read-before-write).
- No backpressure. The downstream stage must accept every `valid_o` cycle.

## Configuration
- `BF16_SCALE_EN`:
  - Defined: FIRST-phase sum and difference are divided by 2 with round-half-up (add 1, arithmetic shift right by 1) before the 19-bit result is taken. This gives per-stage 1/2 scaling and no saturation on the butterfly.
  - Undefined: full-scale sum/difference with saturation, as described in Operation.
- The multiply path is identical in both builds.

## Structure
- Shared package `fft_pkg`:
  - `DATA_W`, `TW_W`, `TW_FRAC` (= 7).
  - The state encoding constants IDLE/FIRST/SECOND/WAITING, shared with all control units.
  - A saturate-to-`DATA_W` function.
- One sub-module: `cmul_q7`. It is a combinational complex multiplier with rounding and saturation, and is reused by later stages.
- The delay line is inferred inside `bf_stage16` (register array, no memory macro).

## Test plan
- DC frame, scaling off:
  - Stimulus: 32 samples (1000,0) through the WAITING/FIRST/SECOND sequence; WN = (128,0).
  - Response: 16 outputs (2000,0), then 16 outputs (0,0); `last_o` on output 32.
- Sign flip:
  - Stimulus: samples 0–15 = (1000,0), samples 16–31 = (-1000,0); WN = (0,-128) throughout SECOND.
  - Response: 16 × (0,0), then 16 × (0,-2000).
- Saturation:
  - Stimulus: all samples = (200000,-200000).
  - Response, scaling off: FIRST outputs (262143,-262144).
  - Response, `BF16_SCALE_EN` defined: FIRST outputs (200000,-200000).
- Rounding:
  - Stimulus: d = (3,0) with WN = (64,0).
  - Response: output (2,0), since 192 + 64 = 256 >> 7 = 2.
  - Stimulus: d = (1,0) with WN = (63,0).
  - Response: output (0,0).
- Reset mid-FIRST:
  - Stimulus: assert `rst` low at FIRST cycle 5.
  - Response: outputs and `valid_o` go to 0 immediately, with no further valid outputs. A following clean frame of the DC test reproduces the DC expected output exactly.
- Abort:
  - Stimulus: state goes FIRST→IDLE after 8 sums, then a full new frame.
  - Response: `valid_o` drops the cycle after IDLE. The new frame yields exactly 32 correct outputs, with `last_o` on the 32nd.
